// File: rtl/ula_pkg.sv
// Shared types and constants for the multicycle ULA: op encodings, handshake
// FSM states and NZCV flag bit positions.
package ula_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_ORR = 3'b011,
      OP_EOR = 3'b100,
      OP_LSL = 3'b101,
      OP_LSR = 3'b110,
      OP_MUL = 3'b111
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE,
      MULT,
      DONE
   } state_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/ula_mult_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles
// after start. done/product are combinational so the caller registers them.
module ula_mult_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

   logic [WIDTH-1:0] a_q, b_q, acc_q;
   logic [CW-1:0]    cnt_q;
   logic             active_q;

   // product already includes this cycle's partial sum, so the last step
   // can be captured by the caller on the same edge that ends the run.
   assign product = acc_q + (b_q[0] ? a_q : '0);
   assign done    = active_q && (cnt_q == '0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (start) begin
         a_q      <= a;
         b_q      <= b;
         acc_q    <= '0;
         cnt_q    <= CNT_MAX;
         active_q <= 1'b1;
      end else if (active_q) begin
         acc_q <= product;
         a_q   <= a_q << 1;
         b_q   <= b_q >> 1;
         if (cnt_q == '0) active_q <= 1'b0;
         else             cnt_q    <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/ula_multiciclo.sv
// Multicycle ULA: valid/ready handshake FSM, combinational single-cycle ALU and
// an iterative multiplier, with Result and NZCV flags registered together.
module ula_multiciclo
   import ula_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       ALUControl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic [3:0]       ALUFlags,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);

   state_t           state, state_nxt;
   alu_op_t          op;
   logic             xfer, is_mul, is_sub;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;
   logic [WIDTH-1:0] b_eff, alu_res;
   logic [WIDTH:0]   sum;
   logic [SHW-1:0]   shamt;
   logic [3:0]       alu_flags, mul_flags;

   assign op     = alu_op_t'(ALUControl);
   assign is_mul = (op == OP_MUL);
   assign is_sub = (op == OP_SUB);
   assign xfer   = in_valid && in_ready;
   assign shamt  = B[SHW-1:0];

   // SUB reuses the adder as A + ~B + 1, so carry-out means "no borrow".
   assign b_eff = is_sub ? ~B : B;
   assign sum   = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

   ula_mult_iter #(.WIDTH(WIDTH)) u_mult (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (xfer && is_mul),
      .a       (A),
      .b       (B),
      .done    (mul_done),
      .product (mul_product)
   );

   // NOTE: every combinational output gets a default first, so no path
   // through the case leaves it unassigned and infers a latch.
   always_comb begin
      alu_res   = '0;
      alu_flags = '0;
      unique case (op)
         OP_ADD, OP_SUB: begin
            alu_res           = sum[WIDTH-1:0];
            alu_flags[FLAG_C] = sum[WIDTH];
            alu_flags[FLAG_V] = (A[WIDTH-1] == b_eff[WIDTH-1]) &&
                                (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND: alu_res = A & B;
         OP_ORR: alu_res = A | B;
         OP_EOR: alu_res = A ^ B;
         OP_LSL: alu_res = A << shamt;
         OP_LSR: alu_res = A >> shamt;
         OP_MUL: alu_res = '0;
      endcase
      alu_flags[FLAG_N] = alu_res[WIDTH-1];
      alu_flags[FLAG_Z] = (alu_res == '0);

      mul_flags         = '0;
      mul_flags[FLAG_N] = mul_product[WIDTH-1];
      mul_flags[FLAG_Z] = (mul_product == '0);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (xfer) state_nxt = is_mul ? MULT : DONE;
         MULT: if (mul_done) state_nxt = DONE;
         DONE: if (out_ready) begin
            if (xfer) state_nxt = is_mul ? MULT : DONE;
            else      state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE: in_ready = reset_n;
         MULT: busy = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            in_ready  = reset_n && out_ready;
         end
         default: ;
      endcase
   end

   // Result/flags move only on the edge that makes out_valid rise.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         Result   <= '0;
         ALUFlags <= '0;
      end else if (xfer && !is_mul) begin
         Result   <= alu_res;
         ALUFlags <= alu_flags;
      end else if (mul_done) begin
         Result   <= mul_product;
         ALUFlags <= mul_flags;
      end
   end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Self-checking bench for ula_multiciclo: directed corner cases plus random
// operands checked against an arithmetic reference model.
module tb_ula_multiciclo;

   localparam int WIDTH = 32;
   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_ORR = 3'd3,
                          OP_EOR = 3'd4, OP_LSL = 3'd5, OP_LSR = 3'd6, OP_MUL = 3'd7;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a_in = '0;
   logic [WIDTH-1:0] b_in = '0;
   logic [2:0]       alu_control = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] result;
   logic [3:0]       alu_flags;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   ula_multiciclo #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .A          (a_in),
      .B          (b_in),
      .ALUControl (alu_control),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .Result     (result),
      .ALUFlags   (alu_flags),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: plain integer arithmetic, flags from value ranges.
   function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic [3:0] f);
      logic [32:0] wide;
      logic [63:0] prod;
      longint      sr;
      logic        c, v;
      c = 1'b0;
      v = 1'b0;
      r = '0;
      case (op)
         OP_ADD: begin
            wide = {1'b0, a} + {1'b0, b};
            r    = wide[31:0];
            c    = wide[32];
            sr   = longint'($signed(a)) + longint'($signed(b));
            v    = (sr != longint'($signed(r)));
         end
         OP_SUB: begin
            r  = a - b;
            c  = (a >= b);
            sr = longint'($signed(a)) - longint'($signed(b));
            v  = (sr != longint'($signed(r)));
         end
         OP_AND: r = a & b;
         OP_ORR: r = a | b;
         OP_EOR: r = a ^ b;
         OP_LSL: r = a << (b % 32);
         OP_LSR: r = a >> (b % 32);
         default: begin
            prod = 64'(a) * 64'(b);
            r    = prod[31:0];
         end
      endcase
      f = {r[31], (r == 32'd0), c, v};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one op, waits for acceptance and then for out_valid. extra is the
   // number of edges after the accepting edge until out_valid was seen.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [3:0] f,
                        output int extra, output int busy_cnt, output int rdy_cnt);
      int guard;
      alu_control = op;
      a_in        = a;
      b_in        = b;
      in_valid    = 1'b1;
      #1;
      guard = 0;
      while (!in_ready && guard < 100) begin
         tick();
         guard++;
      end
      tick();
      in_valid = 1'b0;
      extra    = 0;
      busy_cnt = 0;
      rdy_cnt  = 0;
      while (!out_valid && extra < 100) begin
         if (busy) busy_cnt++;
         if (in_ready) rdy_cnt++;
         tick();
         extra++;
      end
      r = result;
      f = alu_flags;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
          result !== 32'd0 || alu_flags !== 4'd0) begin
         failures++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b result=%h flags=%b, required 0 0 0 0 0",
                  in_ready, out_valid, busy, result, alu_flags);
      end
      reset_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic test_add();
      logic [31:0] r, er, a, b;
      logic [3:0]  f, ef;
      int          ex, bc, rc;
      do_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, r, f, ex, bc, rc);
      consume();
      checks++;
      if (r !== 32'h8000_0000 || f !== 4'b1001 || ex !== 0) begin
         failures++;
         $display("FAIL add_overflow: result=%h flags=%b extra=%0d, required 80000000 1001 0", r, f, ex);
      end
      for (int i = 0; i < 12; i++) begin
         a = $urandom;
         b = (i % 3 == 0) ? ~a + 32'd1 : $urandom;
         do_op(OP_ADD, a, b, r, f, ex, bc, rc);
         consume();
         model(OP_ADD, a, b, er, ef);
         checks++;
         if (r !== er || f !== ef || ex !== 0) begin
            failures++;
            $display("FAIL add_random: %h+%h result=%h flags=%b extra=%0d, required %h %b 0", a, b, r, f, ex, er, ef);
         end
      end
   endtask

   task automatic test_sub();
      logic [31:0] r, er, a, b;
      logic [3:0]  f, ef;
      int          ex, bc, rc;
      do_op(OP_SUB, 32'd5, 32'd5, r, f, ex, bc, rc);
      consume();
      checks++;
      if (r !== 32'd0 || f !== 4'b0110) begin
         failures++;
         $display("FAIL sub_equal: result=%h flags=%b, required 00000000 0110", r, f);
      end
      do_op(OP_SUB, 32'd0, 32'd1, r, f, ex, bc, rc);
      consume();
      checks++;
      if (r !== 32'hFFFF_FFFF || f !== 4'b1000) begin
         failures++;
         $display("FAIL sub_borrow: result=%h flags=%b, required ffffffff 1000", r, f);
      end
      for (int i = 0; i < 12; i++) begin
         a = $urandom;
         b = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
         do_op(OP_SUB, a, b, r, f, ex, bc, rc);
         consume();
         model(OP_SUB, a, b, er, ef);
         checks++;
         if (r !== er || f !== ef) begin
            failures++;
            $display("FAIL sub_random: %h-%h result=%h flags=%b, required %h %b", a, b, r, f, er, ef);
         end
      end
   endtask

   task automatic test_logic();
      logic [31:0] r, er, a, b;
      logic [3:0]  f, ef;
      logic [2:0]  op;
      int          ex, bc, rc;
      for (int i = 0; i < 15; i++) begin
         op = OP_AND + 3'(i % 3);
         a  = $urandom;
         b  = (i == 0) ? ~a : $urandom;
         do_op(op, a, b, r, f, ex, bc, rc);
         consume();
         model(op, a, b, er, ef);
         checks++;
         if (r !== er || f !== ef) begin
            failures++;
            $display("FAIL logic_random: op=%0d a=%h b=%h result=%h flags=%b, required %h %b", op, a, b, r, f, er, ef);
         end
      end
   endtask

   task automatic test_shift();
      logic [31:0] r, er, a, b;
      logic [3:0]  f, ef;
      logic [2:0]  op;
      int          ex, bc, rc;
      do_op(OP_LSL, 32'h0000_0001, 32'hFFFF_FF25, r, f, ex, bc, rc);
      consume();
      checks++;
      if (r !== 32'h0000_0020 || f !== 4'b0000) begin
         failures++;
         $display("FAIL lsl_upper_ignored: result=%h flags=%b, required 00000020 0000", r, f);
      end
      do_op(OP_LSR, 32'h8000_0000, 32'd31, r, f, ex, bc, rc);
      consume();
      checks++;
      if (r !== 32'h0000_0001 || f !== 4'b0000) begin
         failures++;
         $display("FAIL lsr_31: result=%h flags=%b, required 00000001 0000", r, f);
      end
      for (int i = 0; i < 12; i++) begin
         op = (i % 2 == 0) ? OP_LSL : OP_LSR;
         a  = $urandom;
         b  = $urandom;
         do_op(op, a, b, r, f, ex, bc, rc);
         consume();
         model(op, a, b, er, ef);
         checks++;
         if (r !== er || f !== ef) begin
            failures++;
            $display("FAIL shift_random: op=%0d a=%h b=%h result=%h flags=%b, required %h %b", op, a, b, r, f, er, ef);
         end
      end
   endtask

   task automatic test_mul();
      logic [31:0] r, er, a, b;
      logic [3:0]  f, ef;
      int          ex, bc, rc;
      do_op(OP_MUL, 32'h0000_FFFF, 32'h0001_0001, r, f, ex, bc, rc);
      checks++;
      if (r !== 32'hFFFF_FFFF || f !== 4'b1000) begin
         failures++;
         $display("FAIL mul_directed: result=%h flags=%b, required ffffffff 1000", r, f);
      end
      checks++;
      if (ex !== WIDTH || bc !== WIDTH || rc !== 0) begin
         failures++;
         $display("FAIL mul_timing: extra=%0d busy_cycles=%0d ready_cycles=%0d, required %0d %0d 0",
                  ex, bc, rc, WIDTH, WIDTH);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL mul_busy_clear: busy=%b required 0", busy);
      end
      consume();
      for (int i = 0; i < 5; i++) begin
         a = $urandom;
         b = (i == 0) ? 32'd0 : $urandom;
         do_op(OP_MUL, a, b, r, f, ex, bc, rc);
         consume();
         model(OP_MUL, a, b, er, ef);
         checks++;
         if (r !== er || f !== ef || ex !== WIDTH) begin
            failures++;
            $display("FAIL mul_random: %h*%h result=%h flags=%b extra=%0d, required %h %b %0d",
                     a, b, r, f, ex, er, ef, WIDTH);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] r, er, a, b;
      logic [3:0]  f, ef;
      int          ex, bc, rc, bad;
      do_op(OP_ORR, 32'h8000_0F00, 32'h0000_00F0, r, f, ex, bc, rc);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (result !== 32'h8000_0FF0 || alu_flags !== 4'b1000 || out_valid !== 1'b1 || in_ready !== 1'b0)
            bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL backpressure_hold: %0d bad cycles (last result=%h flags=%b valid=%b ready=%b), required 0",
                  bad, result, alu_flags, out_valid, in_ready);
      end
      a = $urandom;
      b = $urandom;
      out_ready   = 1'b1;
      in_valid    = 1'b1;
      alu_control = OP_ADD;
      a_in        = a;
      b_in        = b;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL backpressure_release_ready: in_ready=%b required 1", in_ready);
      end
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      model(OP_ADD, a, b, er, ef);
      checks++;
      if (out_valid !== 1'b1 || result !== er || alu_flags !== ef) begin
         failures++;
         $display("FAIL backpressure_next_add: valid=%b result=%h flags=%b, required 1 %h %b",
                  out_valid, result, alu_flags, er, ef);
      end
      consume();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL valid_drop: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_reset_mid_mul();
      logic [31:0] r;
      logic [3:0]  f;
      int          ex, bc, rc, spurious;
      alu_control = OP_MUL;
      a_in        = 32'h1234_5678;
      b_in        = 32'h0000_0F0F;
      in_valid    = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      reset_n = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 ||
          result !== 32'd0 || alu_flags !== 4'd0) begin
         failures++;
         $display("FAIL reset_mid_mul: valid=%b busy=%b ready=%b result=%h flags=%b, required 0 0 0 0 0",
                  out_valid, busy, in_ready, result, alu_flags);
      end
      reset_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_mul_idle: in_ready=%b required 1", in_ready);
      end
      spurious = 0;
      for (int i = 0; i < WIDTH + 4; i++) begin
         tick();
         if (out_valid !== 1'b0 || busy !== 1'b0) spurious++;
      end
      checks++;
      if (spurious != 0) begin
         failures++;
         $display("FAIL reset_mid_mul_quiet: %0d cycles with activity, required 0", spurious);
      end
      do_op(OP_ADD, 32'd2, 32'd3, r, f, ex, bc, rc);
      consume();
      checks++;
      if (r !== 32'd5 || f !== 4'b0000 || ex !== 0) begin
         failures++;
         $display("FAIL add_after_reset: result=%h flags=%b extra=%0d, required 00000005 0000 0", r, f, ex);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  ops[10];
      logic [31:0] as[10], bs[10];
      logic [31:0] er;
      logic [3:0]  ef;
      for (int i = 0; i < 10; i++) begin
         ops[i] = 3'($urandom_range(0, 6));
         as[i]  = $urandom;
         bs[i]  = $urandom;
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         alu_control = ops[i];
         a_in        = as[i];
         b_in        = bs[i];
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready[%0d]: in_ready=%b required 1", i, in_ready);
         end
         tick();
         model(ops[i], as[i], bs[i], er, ef);
         checks++;
         if (out_valid !== 1'b1 || result !== er || alu_flags !== ef) begin
            failures++;
            $display("FAIL b2b_result[%0d]: op=%0d valid=%b result=%h flags=%b, required 1 %h %b",
                     i, ops[i], out_valid, result, alu_flags, er, ef);
         end
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drain: out_valid=%b required 0", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_shift();
      test_mul();
      test_backpressure();
      test_reset_mid_mul();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ula_multiciclo.md
# ula_multiciclo

Parametrised, multi-cycle successor of the 32-bit combinational ULA. It adds a registered result with ARM-style NZCV flags, a valid/ready handshake on both sides, three new operations (EOR, LSL, LSR) and an iterative shift-add MUL. It sits between the register-file read stage and the write-back mux of the multicycle datapath.

## Interface
- WIDTH, 32: operand and result width; ≥ 8, power of two.
- SHW, $clog2(WIDTH): shift-amount bits taken from B[SHW-1:0]; derived, not overridden.
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset. One clock; reset is synchronous and active-low.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block accepts this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- ALUControl  in  3  op: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 LSL, 110 LSR, 111 MUL.
- out_valid  out  1  Result/ALUFlags valid.
- out_ready  in  1  consumer takes the result.
- Result  out  WIDTH  registered result.
- ALUFlags  out  4  {N,Z,C,V}, registered with Result.
- busy  out  1  high while state is MULT.

## Operation
- States: IDLE, MULT, DONE.
- in_ready = reset_n && (state==IDLE || (state==DONE && out_ready)). Transfer = in_valid && in_ready, sampled at the rising edge.
- Transfer with op ≠ MUL: compute combinationally, register Result/flags, go to DONE.
- Transfer with op = MUL: latch A, B, clear accumulator, load counter = WIDTH-1, go to MULT.
- MULT: each cycle add (B[0] ? A : 0) to the accumulator, A <<= 1, B >>= 1. When the counter is 0, register the result and go to DONE. Otherwise decrement.
- DONE: hold Result/flags stable while out_ready=0. On out_ready=1: go to IDLE, or go to the new op's path if a transfer occurs in the same cycle. This gives back-to-back single-cycle ops at 1/cycle.
- Arithmetic: ADD/SUB use a WIDTH+1-bit sum. SUB = A + ~B + 1.
  - C = carry-out; for SUB, C=1 means no borrow.
  - V = (A[msb]==B'[msb]) && (Sum[msb]!=A[msb]), where B' is the inverted B for SUB.
- Logic/shift ops: C=0, V=0. Shifts are logical and use B[SHW-1:0] only; the upper bits of B are ignored.
- MUL: Result = low WIDTH bits of A*B (unsigned = signed low half). C=0, V=0.
- All ops: N = Result[WIDTH-1], Z = (Result==0).
- in_valid while in_ready=0 is ignored. The source must hold its data; the block does not latch it.

## Timing
- Reset (reset_n=0 at an edge), from any state including mid-MUL:
  - state=IDLE, out_valid=0, Result=0, ALUFlags=0, busy=0, counter=0.
  - in_ready=0 while reset_n=0.
- Single-cycle op accepted at edge k: out_valid=1 after edge k, i.e. latency 1.
- MUL accepted at edge k: busy=1 after edges k..k+WIDTH-1. out_valid=1 after edge k+WIDTH, i.e. latency WIDTH. in_ready=0 throughout.
- Result/ALUFlags change only on the edge that sets out_valid.
- out_valid drops the edge after out_ready=1, unless a new single-cycle op was accepted at that same edge.

## Structure
- Package ula_pkg holds:
  - alu_op_t enum (3-bit, encodings above);
  - state_t enum {IDLE, MULT, DONE};
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module ula_mult_iter (WIDTH param): start/done interface, owns the counter, shift registers and accumulator. The top level keeps the handshake FSM and the combinational single-cycle ALU.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 -> Result 0x80000000, flags 1001, out_valid one cycle after accept.
- SUB 5 - 5 -> 0x00000000, flags 0110. SUB 0 - 1 -> 0xFFFFFFFF, flags 1000.
- LSL A=0x00000001, B=0xFFFFFF25 (shamt 5) -> 0x00000020. LSR A=0x80000000, B=31 -> 0x00000001.
- MUL 0x0000FFFF * 0x00010001 -> 0xFFFFFFFF, flags 1000.
  - out_valid exactly 32 cycles after accept.
  - busy=1 for those 32 cycles.
  - in_ready=0 during MULT.
- Backpressure: hold out_ready=0 for 5 cycles after an ORR.
  - Result and flags stay stable and in_ready=0.
  - Then out_ready=1 with a new ADD in the same cycle: accepted, next result one cycle later.
- reset_n=0 for one edge at MUL cycle 10 -> all outputs 0 and state IDLE. The next ADD 2+3 -> 0x00000005.
